pc_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory. It drives current_pc, which the memory uses combinationally to return the 9-bit instruction.
- It holds a start/done run handshake and a small writable branch-target lookup table (LUT), since 9-bit instructions cannot encode full jump addresses.
- It applies halt, absolute-jump, relative-branch and stall requests from the decode/control stage, and counts retired fetches.

---
 rtl/pc_fetch_unit.sv | 122 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer in front of the instruction memory.
// Applies start/halt/stall/jump/branch, tracks wrap-around and counts PC advances.
module pc_fetch_unit #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned ADDR_LIMIT = 4096,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LUT_DEPTH  = 16,
  parameter int unsigned LUT_IDX_W  = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 jump_en,
  input  logic                 branch_taken,
  input  logic [7:0]           branch_off,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [11:0]          lut_wdata,
  output logic [PC_WIDTH-1:0]  current_pc,
  output logic                 running,
  output logic                 done,
  output logic                 pc_wrap,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] ADDR_MASK = PC_WIDTH'(ADDR_LIMIT - 1);
  localparam logic [PC_WIDTH:0]   LIMIT_M1  = (PC_WIDTH + 1)'(ADDR_LIMIT - 1);
  localparam logic [PC_WIDTH-1:0] START_PC  = PC_WIDTH'(START_ADDR) & ADDR_MASK;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic                 running_q, done_q;
  logic [11:0]          lut_q [LUT_DEPTH];

  logic [PC_WIDTH:0]    step_sum;
  logic [PC_WIDTH-1:0]  jump_pc;

  // Unreduced sum one bit wider than the PC: a negative result shows up as a
  // huge value, so a single compare catches wrap in both directions.
  assign step_sum = {1'b0, pc_q} + (branch_taken
                    ? {{(PC_WIDTH - 7){branch_off[7]}}, branch_off}
                    : (PC_WIDTH + 1)'(1));
  assign jump_pc  = PC_WIDTH'(lut_q[lut_idx]) & ADDR_MASK;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (state_q == ST_IDLE) pc_d = START_PC;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (start) begin
          pc_d   = START_PC;
          cnt_d  = '0;
          wrap_d = 1'b0;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (!stall) begin
          if (jump_en) begin
            pc_d = jump_pc;
          end else begin
            pc_d = step_sum[PC_WIDTH-1:0] & ADDR_MASK;
            if (step_sum > LIMIT_M1) wrap_d = 1'b1;
          end
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < int'(LUT_DEPTH); i++) lut_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_HALTED);
      // A same-cycle jump already read the old entry combinationally.
      if (lut_we) lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign current_pc  = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pc_wrap     = wrap_q;
  assign fetch_count = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected PCs go through a queue per cycle,
// flags and counter are checked against hand-derived constants.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, halt, jump_en, branch_taken, lut_we;
  logic [7:0]  branch_off;
  logic [3:0]  lut_idx, lut_waddr;
  logic [11:0] lut_wdata;
  logic [31:0] current_pc, fetch_count;
  logic        running, done, pc_wrap;
  logic [1:0]  state_o;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .jump_en(jump_en), .branch_taken(branch_taken), .branch_off(branch_off),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .current_pc(current_pc), .running(running), .done(done), .pc_wrap(pc_wrap),
    .fetch_count(fetch_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the PC expected after the coming edge, clock once, pop and compare.
  task automatic step(input string tag, input logic [31:0] exp_pc);
    logic [31:0] e;
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, current_pc, e);
  endtask

  task automatic chk_flags(input string tag, input logic run_e, input logic done_e,
                           input logic wrap_e, input logic [31:0] cnt_e);
    chk({tag, "_running"}, {31'd0, running}, {31'd0, run_e});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, done_e});
    chk({tag, "_wrap"}, {31'd0, pc_wrap}, {31'd0, wrap_e});
    chk({tag, "_cnt"}, fetch_count, cnt_e);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0; jump_en = 1'b0;
    branch_taken = 1'b0; branch_off = 8'd0; lut_idx = 4'd0; lut_we = 1'b0;
    lut_waddr = 4'd0; lut_wdata = 12'd0;
    step("rst_pc0", 32'd0);
    step("rst_pc1", 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    reset = 1'b0;
    step("idle_pc", 32'd0);

    // Start and free-run
    start = 1'b1;
    step("start_pc", 32'd0);
    chk_flags("start", 1'b1, 1'b0, 1'b0, 32'd0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step("run_pc", 32'(i));
    chk_flags("run5", 1'b1, 1'b0, 1'b0, 32'd5);

    // LUT write, then jumps with and without a same-cycle write
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'h120;
    step("lutw_pc", 32'd6);
    lut_we = 1'b0;
    for (int i = 7; i <= 10; i++) step("run_pc", 32'(i));
    jump_en = 1'b1; lut_idx = 4'd3;
    step("jump_120", 32'h120);
    lut_we = 1'b1; lut_wdata = 12'h200;
    step("jump_old", 32'h120);
    lut_we = 1'b0;
    step("jump_new", 32'h200);
    chk_flags("jump", 1'b1, 1'b0, 1'b0, 32'd13);

    // Negative branch below zero
    jump_en = 1'b0; lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 12'h005;
    step("inc_201", 32'h201);
    lut_we = 1'b0; jump_en = 1'b1; lut_idx = 4'd5;
    step("jump_5", 32'h5);
    chk("pre_bwrap", {31'd0, pc_wrap}, 32'd0);
    jump_en = 1'b0; branch_taken = 1'b1; branch_off = 8'hF8;
    step("br_neg", 32'hFFD);
    chk_flags("br_neg", 1'b1, 1'b0, 1'b1, 32'd16);
    branch_taken = 1'b0;

    // Restart clears wrap; jump to top does not set it; increment past top does
    start = 1'b1; lut_we = 1'b1; lut_waddr = 4'd6; lut_wdata = 12'hFFF;
    step("restart", 32'd0);
    chk_flags("restart", 1'b1, 1'b0, 1'b0, 32'd0);
    start = 1'b0; lut_we = 1'b0; jump_en = 1'b1; lut_idx = 4'd6;
    step("jump_fff", 32'hFFF);
    chk("jump_nowrap", {31'd0, pc_wrap}, 32'd0);
    jump_en = 1'b0;
    step("inc_wrap", 32'd0);
    chk_flags("inc_wrap", 1'b1, 1'b0, 1'b1, 32'd2);
    start = 1'b1;
    step("restart2", 32'd0);
    chk_flags("restart2", 1'b1, 1'b0, 1'b0, 32'd0);

    // Stall beats jump and branch
    start = 1'b0; lut_we = 1'b1; lut_waddr = 4'd7; lut_wdata = 12'h007;
    step("inc_1", 32'd1);
    lut_we = 1'b0; jump_en = 1'b1; lut_idx = 4'd7;
    step("jump_7", 32'd7);
    stall = 1'b1; lut_idx = 4'd3; branch_taken = 1'b1; branch_off = 8'd4;
    step("stall1", 32'd7);
    step("stall2", 32'd7);
    chk("stall_cnt", fetch_count, 32'd2);
    stall = 1'b0; jump_en = 1'b0;
    step("br_p4", 32'd11);
    branch_off = 8'd9;
    step("br_p9", 32'd20);

    // Halt, ignored controls while halted, restart
    branch_taken = 1'b0; halt = 1'b1;
    step("halt_pc", 32'd20);
    chk_flags("halt", 1'b0, 1'b1, 1'b0, 32'd4);
    halt = 1'b0; jump_en = 1'b1; branch_taken = 1'b1;
    step("halted_ign", 32'd20);
    chk_flags("halted", 1'b0, 1'b1, 1'b0, 32'd4);
    jump_en = 1'b0; branch_taken = 1'b0; start = 1'b1;
    step("halt_start", 32'd0);
    chk_flags("halt_start", 1'b1, 1'b0, 1'b0, 32'd0);

    // Reset mid-run overrides a LUT write
    start = 1'b0; branch_taken = 1'b1; branch_off = 8'd50;
    step("br_50", 32'd50);
    branch_taken = 1'b0; reset = 1'b1; lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'h7;
    step("mid_rst", 32'd0);
    chk_flags("mid_rst", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mid_rst_state", {30'd0, state_o}, 32'd0);
    reset = 1'b0; lut_we = 1'b0; jump_en = 1'b1; lut_idx = 4'd3;
    step("idle_ign", 32'd0);
    jump_en = 1'b0; start = 1'b1;
    step("start3", 32'd0);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      jump_en = 1'b0;
      step("lut_inc", 32'd1);
      jump_en = 1'b1; lut_idx = 4'(i);
      step("lut_zero", 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
